// File: rtl/serial_sub.sv
// serial_sub: multi-cycle unsigned subtractor, Diff = A - B - Bin (mod 2^WIDTH).
// Each clock in RUN handles DIGIT bits, least significant digit first. The
// borrow between digits is kept in a flip-flop. A Start/Done handshake frames
// each job.
// Optional feature: define SERIAL_SUB_OVF_EN to add the Ovf output, which
// reports two's-complement overflow of the subtraction.
module serial_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             Ovf,
`endif
    output logic             Borrow
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int RW   = (WIDTH > DIGIT) ? (WIDTH - DIGIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    // Reject illegal parameter combinations at elaboration time.
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $fatal(1, "serial_sub: WIDTH must be >= 2 and divisible by DIGIT");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [WIDTH-1:0]  a_sh_reg;
    logic [WIDTH-1:0]  b_sh_reg;
    logic              brw_reg;
    logic [CW-1:0]     count_reg;
    logic [RW-1:0]     res_reg;
    logic [WIDTH-1:0]  diff_reg;
    logic              borrow_reg;
    logic              done_reg;

    logic [DIGIT-1:0]  a_dig;
    logic [DIGIT-1:0]  b_dig;
    logic [DIGIT:0]    dig_sub;
    logic [DIGIT-1:0]  d_dig;
    logic              brw_next;
    logic [WIDTH-1:0]  res_shift;
    logic              last_digit;

    // One digit of subtraction. The extra top bit of dig_sub is set exactly
    // when a_dig < b_dig + brw, so it serves directly as the next borrow.
    assign a_dig    = a_sh_reg[DIGIT-1:0];
    assign b_dig    = b_sh_reg[DIGIT-1:0];
    assign dig_sub  = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, brw_reg};
    assign d_dig    = dig_sub[DIGIT-1:0];
    assign brw_next = dig_sub[DIGIT];

    // Partial result register. The newest digit enters at the MSB end. Only
    // WIDTH-DIGIT bits need storing, because the final digit goes straight
    // into Diff.
    if (WIDTH > DIGIT) begin : g_res_wide
        assign res_shift = {d_dig, res_reg};
    end else begin : g_res_single
        assign res_shift = d_dig;
    end

    assign last_digit = (state_reg == RUN) && (count_reg == LAST);

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: accept Start only while idle, and leave RUN on the last digit.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (Start) state_next = RUN;
            RUN:     if (count_reg == LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, process one digit per clock in RUN,
    // and publish the result together with the one-cycle Done pulse.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            brw_reg    <= 1'b0;
            count_reg  <= '0;
            res_reg    <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg == IDLE) begin
                if (Start) begin
                    a_sh_reg  <= A;
                    b_sh_reg  <= B;
                    brw_reg   <= Bin;
                    count_reg <= '0;
                end
            end else begin
                a_sh_reg  <= a_sh_reg >> DIGIT;
                b_sh_reg  <= b_sh_reg >> DIGIT;
                brw_reg   <= brw_next;
                count_reg <= count_reg + 1'b1;
                res_reg   <= res_shift[WIDTH-1:WIDTH-RW];
                if (last_digit) begin
                    diff_reg   <= res_shift;
                    borrow_reg <= brw_next;
                    done_reg   <= 1'b1;
                end
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_reg;
    logic b_msb_reg;
    logic ovf_reg;

    // Keep the operand sign bits from accept time. Overflow is judged against
    // the final result sign when Diff is loaded.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            if (state_reg == IDLE && Start) begin
                a_msb_reg <= A[WIDTH-1];
                b_msb_reg <= B[WIDTH-1];
            end
            if (last_digit) begin
                ovf_reg <= (a_msb_reg ^ b_msb_reg) & (res_shift[WIDTH-1] ^ a_msb_reg);
            end
        end
    end

    assign Ovf = ovf_reg;
`endif

    assign Busy   = (state_reg == RUN);
    assign Done   = done_reg;
    assign Diff   = diff_reg;
    assign Borrow = borrow_reg;

endmodule
